serdiv_label_wrapper: RTL and testbench
=======================================

// Module: serdiv_label_wrapper
// PURPOSE
//  Serial (radix-2, one bit per cycle) integer divider/remainder unit with information-flow labels.
//  A wrapper around the CVA6-style serdiv datapath: 1-bit security labels on the operands travel with the op.
//  The result label is the OR of the operand labels (taint propagation).
//  Sits in the EX stage beside the multiplier; the trans-ID is passed through for writeback.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk_i         in   1              clock, rising edge
//  rst_ni        in   1              reset; asynchronous, active-low
//  flush_i       in   1              abort any in-flight operation
//  id_i          in   TRANS_ID_BITS  transaction ID of the incoming op
//  op_a_i        in   WIDTH          dividend
//  op_b_i        in   WIDTH          divisor
//  opcode_i      in   2              0 udiv, 1 div, 2 urem, 3 rem
//  in_vld_i      in   1              request valid
//  in_rdy_o      out  1              unit can accept a request
//  out_vld_o     out  1              result valid
//  out_rdy_i     in   1              consumer accepts the result
//  id_o          out  TRANS_ID_BITS  ID of the completed op
//  res_o         out  WIDTH          quotient or remainder
//  op_a_i_label  in   1              label of op_a_i (1 = secret/tainted)
//  op_b_i_label  in   1              label of op_b_i
//  res_o_label   out  1              label of res_o
// BEHAVIOUR
//  - Reset state: IDLE, in_rdy_o=1, out_vld_o=0, res_o=0, id_o=0, res_o_label=0.
//  - FSM states:
//    - IDLE: in_rdy_o=1. On in_vld_i at a clock edge, capture operands, opcode, id_i and
//      label = op_a_i_label|op_b_i_label, then go to DIVIDE.
//    - DIVIDE: exactly WIDTH iteration cycles, in_rdy_o=0. Latency is constant and independent of
//      the operand values; there is no leading-zero skip, which prevents a timing channel.
//    - FINISH: out_vld_o=1 with res_o/id_o/res_o_label held stable until out_rdy_i is seen at a clock
//      edge. The unit then returns to IDLE.
//  - Total latency: out_vld_o rises WIDTH+1 edges after the accept edge.
//  - Output dependencies: out_vld_o and in_rdy_o are driven from FSM state only. There is no
//    combinational path from out_rdy_i or in_vld_i.
//  - Signed ops (opcode[0]=1):
//    - Divide |a| by |b| unsigned.
//    - The quotient is negated when sign(a)!=sign(b).
//    - The remainder takes the sign of a.
//  - Divide by zero: quotient = all ones; remainder = a. Applies to both signed and unsigned.
//  - Signed overflow (a = most negative value, b = -1): quotient = a, remainder = 0.
//  - flush_i: the next edge forces IDLE from any state. out_vld_o drops and the result is discarded.
//    A request presented together with the flush is not accepted. Flush has priority over accept
//    and over completion.
//  - res_o_label is registered and updates only on accept. The label is never cleared by the data value,
//    including the divide-by-zero and overflow cases.
//  - Reset asserted mid-operation: immediate return to the reset state.
// STRUCTURE
//  - TRANS_ID_BITS comes from ariane_pkg. The opcode encoding is a localparam enum in that package.
//  - One sub-module, serdiv_label_core: the unlabelled shift-subtract datapath plus the FSM.
//  - The wrapper adds the label register and the label/ID output muxing.
// TESTING  (WIDTH=8)
//  - udiv 0x20/0x20, labels (0,0),(1,0),(0,1),(1,1) -> res 0x01, label 0,1,1,1 respectively.
//  - Divide by zero, op_b=0x00:
//    - udiv 0x20/0x00 -> 0xFF.
//    - urem 0x20 by 0x00 -> 0x20.
//    - div 0x20/0x00 -> 0xFF.
//  - Signed, opcode 1 then opcode 3:
//    - div 0xF9/0x02 (-7/2) -> 0xFD (-3); rem -> 0xFF (-1).
//    - div 0x80/0xFF -> 0x80; rem -> 0x00.
//  - Latency: out_vld_o rises exactly 9 edges after accept for any operand pair.
//    in_rdy_o stays 0 until out_rdy_i is taken.
//  - Stalled output: hold out_rdy_i=0 for 5 cycles -> res_o/id_o/res_o_label stable; accepted on the
//    first cycle out_rdy_i=1.
//  - Flush and reset:
//    - flush_i in DIVIDE cycle 3 -> in_rdy_o=1 next cycle, no out_vld_o.
//    - The next op (id 5, 0x09/0x03) -> 0x03 with id_o=5.
//    - rst_ni pulsed low mid-op -> all outputs at reset values.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared EX-stage types: transaction ID width, divider opcode encoding and divider FSM states.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [1:0] {
        DIV_UDIV = 2'd0,
        DIV_DIV  = 2'd1,
        DIV_UREM = 2'd2,
        DIV_REM  = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_FINISH
    } div_state_e;

    function automatic logic div_is_signed(input div_op_e op);
        return op[0];
    endfunction

    function automatic logic div_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/serdiv_label_core.sv
// Unlabelled radix-2 restoring divider: fixed WIDTH iterations plus one sign/special-case fixup cycle.
module serdiv_label_core
    import ariane_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [1:0]       opcode_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    div_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             bzero_q, bzero_d;

    logic [WIDTH:0]   trial, diff;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    div_op_e          op_in;
    logic             sgn_in;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign op_in  = div_op_e'(opcode_i);
    assign sgn_in = div_is_signed(op_in);
    assign trial  = {rem_q, quo_q[WIDTH-1]};
    assign diff   = trial - {1'b0, div_q};

    // Divide-by-zero results come from the saved dividend, not the iteration.
    assign quo_fix = bzero_q ? '1  : (negq_q ? -quo_q : quo_q);
    assign rem_fix = bzero_q ? a_q : (negr_q ? -rem_q : rem_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        bzero_d = bzero_q;
        case (state_q)
            S_IDLE: begin
                if (in_vld_i) begin
                    op_d    = op_in;
                    a_d     = op_a_i;
                    div_d   = mag(op_b_i, sgn_in);
                    quo_d   = mag(op_a_i, sgn_in);
                    rem_d   = '0;
                    cnt_d   = '0;
                    negq_d  = sgn_in & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
                    negr_d  = sgn_in & op_a_i[WIDTH-1];
                    bzero_d = (op_b_i == '0);
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (cnt_q != CW'(WIDTH)) begin
                    rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    res_d   = div_is_rem(op_q) ? rem_fix : quo_fix;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (out_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= DIV_UDIV;
            a_q     <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            bzero_q <= bzero_d;
        end
    end

    assign in_rdy_o  = (state_q == S_IDLE);
    assign out_vld_o = (state_q == S_FINISH);
    assign res_o     = res_q;

endmodule

// File: rtl/serdiv_label_wrapper.sv
// Labelled serial divider: result label is the OR of operand labels, captured with the trans-ID on accept.
module serdiv_label_wrapper
    import ariane_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [1:0]               opcode_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [TRANS_ID_BITS-1:0] id_o,
    output logic [WIDTH-1:0]         res_o,
    input  logic                     op_a_i_label,
    input  logic                     op_b_i_label,
    output logic                     res_o_label
);

    logic [TRANS_ID_BITS-1:0] id_q, id_d;
    logic                     lbl_q, lbl_d;
    logic                     accept;

    serdiv_label_core #(.WIDTH(WIDTH)) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .opcode_i  (opcode_i),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .res_o     (res_o)
    );

    // The label depends only on operand labels, never on data, so zero/overflow results stay tainted.
    assign accept = in_vld_i & in_rdy_o & ~flush_i;

    always_comb begin
        id_d  = id_q;
        lbl_d = lbl_q;
        if (accept) begin
            id_d  = id_i;
            lbl_d = op_a_i_label | op_b_i_label;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q  <= '0;
            lbl_q <= 1'b0;
        end else begin
            id_q  <= id_d;
            lbl_q <= lbl_d;
        end
    end

    assign id_o        = id_q;
    assign res_o_label = lbl_q;

endmodule

// File: tb/tb_serdiv_label_wrapper.sv
// Randomized and directed checks of the labelled serial divider against an arithmetic reference.
module tb_serdiv_label_wrapper;
    import ariane_pkg::*;

    localparam int W = 8;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     flush_i = 1'b0;
    logic [TRANS_ID_BITS-1:0] id_i = '0;
    logic [W-1:0]             op_a_i = '0;
    logic [W-1:0]             op_b_i = '0;
    logic [1:0]               opcode_i = '0;
    logic                     in_vld_i = 1'b0;
    logic                     out_rdy_i = 1'b0;
    logic                     op_a_i_label = 1'b0;
    logic                     op_b_i_label = 1'b0;
    logic                     in_rdy_o, out_vld_o, res_o_label;
    logic [TRANS_ID_BITS-1:0] id_o;
    logic [W-1:0]             res_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    serdiv_label_wrapper #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .id_i         (id_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .opcode_i     (opcode_i),
        .in_vld_i     (in_vld_i),
        .in_rdy_o     (in_rdy_o),
        .out_vld_o    (out_vld_o),
        .out_rdy_i    (out_rdy_i),
        .id_o         (id_o),
        .res_o        (res_o),
        .op_a_i_label (op_a_i_label),
        .op_b_i_label (op_b_i_label),
        .res_o_label  (res_o_label)
    );

    // Reference: plain integer division, truncating toward zero, with the architectural special cases.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
        int x, y, q, r;
        if (b == '0) return op[1] ? a : {W{1'b1}};
        if (op[0]) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = int'(a);
            y = int'(b);
        end
        q = x / y;
        r = x % y;
        return op[1] ? W'(r) : W'(q);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic [TRANS_ID_BITS-1:0] id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [1:0] op, input logic la,
                          input logic lb, input int stall, input string name);
        logic [W-1:0] er;
        logic         el;
        int           n;
        er = model(a, b, op);
        el = la | lb;
        n = 0;
        while (!in_rdy_o && n < 40) begin tick(); n++; end
        vectors++;
        if (in_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_rdy_o before issue got %b want 1", name, in_rdy_o);
        end
        id_i = id; op_a_i = a; op_b_i = b; opcode_i = op;
        op_a_i_label = la; op_b_i_label = lb; in_vld_i = 1'b1;
        tick();
        in_vld_i = 1'b0;
        n = 0;
        while (!out_vld_o && n < 20) begin
            vectors++;
            if (in_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL %s in_rdy_o busy cycle %0d got %b want 0", name, n, in_rdy_o);
            end
            tick();
            n++;
        end
        vectors++;
        if (n != W + 1) begin
            miscompares++;
            $display("FAIL %s latency got %0d want %0d", name, n, W + 1);
        end
        for (int s = 0; s <= stall; s++) begin
            vectors++;
            if (out_vld_o !== 1'b1 || res_o !== er || id_o !== id || res_o_label !== el) begin
                miscompares++;
                $display("FAIL %s result hold %0d got vld=%b res=%h id=%0d lbl=%b want vld=1 res=%h id=%0d lbl=%b",
                         name, s, out_vld_o, res_o, id_o, res_o_label, er, id, el);
            end
            if (s < stall) tick();
        end
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        vectors++;
        if (out_vld_o !== 1'b0 || in_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handoff got vld=%b rdy=%b want vld=0 rdy=1", name, out_vld_o, in_rdy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        vectors++;
        if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0 || res_o !== '0 || id_o !== '0 || res_o_label !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got rdy=%b vld=%b res=%h id=%0d lbl=%b want 1 0 00 0 0",
                     in_rdy_o, out_vld_o, res_o, id_o, res_o_label);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_labels();
        for (int i = 0; i < 4; i++)
            run_op(3'(i), 8'h20, 8'h20, 2'd0, i[0], i[1], 0, "label");
    endtask

    task automatic test_div_zero();
        run_op(3'd1, 8'h20, 8'h00, 2'd0, 1'b0, 1'b1, 0, "udiv0");
        run_op(3'd2, 8'h20, 8'h00, 2'd2, 1'b1, 1'b0, 0, "urem0");
        run_op(3'd3, 8'h20, 8'h00, 2'd1, 1'b1, 1'b1, 0, "div0");
        run_op(3'd4, 8'hE0, 8'h00, 2'd3, 1'b0, 1'b0, 0, "rem0");
    endtask

    task automatic test_signed();
        run_op(3'd6, 8'hF9, 8'h02, 2'd1, 1'b0, 1'b0, 0, "div_neg");
        run_op(3'd7, 8'hF9, 8'h02, 2'd3, 1'b0, 1'b0, 0, "rem_neg");
        run_op(3'd0, 8'h80, 8'hFF, 2'd1, 1'b1, 1'b0, 0, "div_ovf");
        run_op(3'd1, 8'h80, 8'hFF, 2'd3, 1'b0, 1'b1, 0, "rem_ovf");
    endtask

    task automatic test_stall();
        run_op(3'd2, 8'hC8, 8'h07, 2'd0, 1'b1, 1'b0, 5, "stall");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 9 == 0) b = '0;
            if (i % 13 == 0) begin a = 8'h80; b = 8'hFF; end
            run_op(TRANS_ID_BITS'($urandom), a, b, 2'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_flush();
        id_i = 3'd6; op_a_i = 8'h64; op_b_i = 8'h05; opcode_i = 2'd0;
        op_a_i_label = 1'b1; op_b_i_label = 1'b1; in_vld_i = 1'b1;
        tick();
        in_vld_i = 1'b0;
        repeat (2) tick();
        flush_i = 1'b1;
        in_vld_i = 1'b1;
        tick();
        flush_i = 1'b0;
        in_vld_i = 1'b0;
        vectors++;
        if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush got rdy=%b vld=%b want rdy=1 vld=0", in_rdy_o, out_vld_o);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (out_vld_o !== 1'b0 || in_rdy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_idle cycle %0d got vld=%b rdy=%b want 0 1", i, out_vld_o, in_rdy_o);
            end
        end
        run_op(3'd5, 8'h09, 8'h03, 2'd0, 1'b1, 1'b0, 0, "post_flush");
    endtask

    task automatic test_reset_mid();
        id_i = 3'd2; op_a_i = 8'h77; op_b_i = 8'h03; opcode_i = 2'd0;
        op_a_i_label = 1'b1; op_b_i_label = 1'b0; in_vld_i = 1'b1;
        tick();
        in_vld_i = 1'b0;
        repeat (4) tick();
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0 || res_o !== '0 || id_o !== '0 || res_o_label !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got rdy=%b vld=%b res=%h id=%0d lbl=%b want 1 0 00 0 0",
                     in_rdy_o, out_vld_o, res_o, id_o, res_o_label);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        run_op(3'd4, 8'h0C, 8'h05, 2'd2, 1'b0, 1'b0, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_labels();
        test_div_zero();
        test_signed();
        test_stall();
        test_random();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
